// File: rtl/sha_round_seq_pkg.sv
// Shared definitions for the SHA round sequencer: state encoding, standard
// terminal counts and default widths.
package sha_seq_pkg;

  localparam int DEF_CNT_W = 7;

  // Terminal round index for each supported digest family.
  localparam int SHA256_LAST = 63;
  localparam int SHA512_LAST = 79;

  typedef logic [1:0] seq_state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/sha_round_seq_if.sv
// Control-side bundle between the SHA control FSM (master) and the round
// sequencer (slave).
interface sha_round_seq_if
  import sha_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  // Handshake: i_start is a request without a ready signal. It is accepted
  // on the rising edge where the sequencer is in IDLE or DONE, or in RUN when
  // count == last and i_hold is low; otherwise it is ignored. i_last_cnt is
  // only meaningful on that accepting edge. i_abort wins over everything.
  logic             i_start;
  logic [CNT_W-1:0] i_last_cnt;
  logic             i_hold;
  logic             i_abort;
  logic [CNT_W-1:0] count;
  logic             flag;
  logic             o_busy;
  logic             o_done;
  logic             o_sched_sel;

  modport master (
    output i_start, i_last_cnt, i_hold, i_abort,
    input  count, flag, o_busy, o_done, o_sched_sel
  );

  modport slave (
    input  i_start, i_last_cnt, i_hold, i_abort,
    output count, flag, o_busy, o_done, o_sched_sel
  );

endinterface

// File: rtl/sha_round_seq.sv
// Round address sequencer for SHA-256/512 with start/hold/abort and chaining.
// Optional completed-block counter enabled by defining SHA_SEQ_BLKCNT_EN.
module sha_round_seq
  import sha_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_CNT     = SHA512_LAST,
`ifdef SHA_SEQ_BLKCNT_EN
  parameter int BLK_W       = 16,
`endif
  parameter int SCHED_SPLIT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  sha_round_seq_if.slave   bus,
`ifdef SHA_SEQ_BLKCNT_EN
  input  logic             i_blk_clr,
  output logic [BLK_W-1:0] o_blk_cnt,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] MAX_Q   = CNT_W'(MAX_CNT);
  localparam logic [31:0]      SPLIT_W = 32'(SCHED_SPLIT);

  seq_state_t       state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] last_q;
  logic             flag_q;
  logic             done_q;

  logic [CNT_W-1:0] last_clamped;
  logic             term_hit;

  // Oversized run-time terminal counts fall back to the largest legal one,
  // which also keeps count from ever reaching the wrap point.
  assign last_clamped = (bus.i_last_cnt > MAX_Q) ? MAX_Q : bus.i_last_cnt;

  assign term_hit = (state_q == ST_RUN) && !bus.i_hold && !bus.i_abort &&
                    (count_q == last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      if (bus.i_abort) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (bus.i_start) begin
              state_q <= ST_RUN;
              count_q <= '0;
              last_q  <= last_clamped;
              done_q  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (term_hit) begin
              flag_q <= 1'b1;
              // A start in the terminal cycle chains the next block with
              // no idle cycle in between.
              if (bus.i_start) begin
                count_q <= '0;
                last_q  <= last_clamped;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end else if (!bus.i_hold) begin
              count_q <= count_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SHA_SEQ_BLKCNT_EN
  logic [BLK_W-1:0] blk_cnt_q;

  // Counts on the same edge that raises flag; clear takes precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_q <= '0;
    end else if (i_blk_clr) begin
      blk_cnt_q <= '0;
    end else if (term_hit && (blk_cnt_q != {BLK_W{1'b1}})) begin
      blk_cnt_q <= blk_cnt_q + 1'b1;
    end
  end

  assign o_blk_cnt = blk_cnt_q;
`endif

  assign bus.count       = count_q;
  assign bus.flag        = flag_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = (state_q == ST_RUN);
  assign bus.o_sched_sel = (state_q == ST_RUN) && (32'(count_q) < SPLIT_W);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sha_round_seq.sv
// Directed self-checking bench for sha_round_seq (SHA-512 sized, MAX_CNT=79).
module tb_sha_round_seq;

  logic clk;
  logic reset_n;
  logic [1:0] dbg_state;
`ifdef SHA_SEQ_BLKCNT_EN
  logic        i_blk_clr;
  logic [15:0] o_blk_cnt;
`endif

  int checks;
  int failures;
  int n;
  int sched_cycles;
  int flag_cycles;

  sha_round_seq_if #(.CNT_W(7)) bus ();

  sha_round_seq #(
    .CNT_W(7),
    .MAX_CNT(79),
`ifdef SHA_SEQ_BLKCNT_EN
    .BLK_W(16),
`endif
    .SCHED_SPLIT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
`ifdef SHA_SEQ_BLKCNT_EN
    .i_blk_clr(i_blk_clr),
    .o_blk_cnt(o_blk_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic start_blk(input logic [6:0] last);
    bus.i_start    = 1'b1;
    bus.i_last_cnt = last;
    n = 0;
    step();
    bus.i_start    = 1'b0;
    bus.i_last_cnt = '0;
  endtask

  task automatic wait_count(input string tag, input int target, input int bound);
    int g;
    g = 0;
    while ((int'(bus.count) != target) && (g < bound)) begin
      step();
      g++;
    end
    chk(tag, 32'(bus.count), 32'(target));
  endtask

  task automatic wait_flag(input string tag, input int bound);
    int g;
    g = 0;
    while ((bus.flag !== 1'b1) && (g < bound)) begin
      step();
      g++;
    end
    chk(tag, 32'(bus.flag), 32'd1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    n            = 0;
    reset_n      = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_last_cnt = '0;
    bus.i_hold     = 1'b0;
    bus.i_abort    = 1'b0;
`ifdef SHA_SEQ_BLKCNT_EN
    i_blk_clr = 1'b0;
`endif

    // Reset values
    repeat (3) step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_flag", 32'(bus.flag), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_sched", 32'(bus.o_sched_sel), 0);
    chk("rst_state", 32'(dbg_state), 0);
`ifdef SHA_SEQ_BLKCNT_EN
    chk("rst_blk", 32'(o_blk_cnt), 0);
`endif
    reset_n = 1'b1;
    step();
    chk("idle_count", 32'(bus.count), 0);
    chk("idle_state", 32'(dbg_state), 0);

    // SHA-256 block: count 0..63, flag at t+65
    start_blk(7'd63);
    sched_cycles = 0;
    flag_cycles  = 0;
    for (int k = 0; k < 64; k++) begin
      chk("a_count", 32'(bus.count), 32'(k));
      chk("a_busy", 32'(bus.o_busy), 1);
      if (bus.o_sched_sel) sched_cycles++;
      if (bus.flag) flag_cycles++;
      step();
    end
    chk("a_n", 32'(n), 65);
    chk("a_flag", 32'(bus.flag), 1);
    chk("a_done", 32'(bus.o_done), 1);
    chk("a_busy_fall", 32'(bus.o_busy), 0);
    chk("a_count_hold", 32'(bus.count), 63);
    chk("a_sched_off", 32'(bus.o_sched_sel), 0);
    chk("a_early_flags", 32'(flag_cycles), 0);
    chk("a_sched_cycles", 32'(sched_cycles), 16);
    step();
    chk("a_flag_pulse", 32'(bus.flag), 0);
    chk("a_done_level", 32'(bus.o_done), 1);
    chk("a_state_done", 32'(dbg_state), 2);
    chk("a_count_done", 32'(bus.count), 63);

    // SHA-512 block with a 3-cycle hold at count=10
    start_blk(7'd79);
    chk("b_done_clr", 32'(bus.o_done), 0);
    chk("b_count0", 32'(bus.count), 0);
    repeat (10) step();
    chk("b_count10", 32'(bus.count), 10);
    bus.i_hold = 1'b1;
    repeat (3) begin
      step();
      chk("b_hold_count", 32'(bus.count), 10);
      chk("b_hold_busy", 32'(bus.o_busy), 1);
    end
    bus.i_hold = 1'b0;
    wait_flag("b_flag", 200);
    chk("b_flag_time", 32'(n), 84);
    chk("b_count_term", 32'(bus.count), 79);

    // Chained blocks: 63 then 79 with no idle cycle
    start_blk(7'd63);
    wait_count("c_reach63", 63, 100);
    chk("c_n63", 32'(n), 64);
    bus.i_start    = 1'b1;
    bus.i_last_cnt = 7'd79;
    step();
    bus.i_start    = 1'b0;
    bus.i_last_cnt = '0;
    chk("c_flag1", 32'(bus.flag), 1);
    chk("c_restart", 32'(bus.count), 0);
    chk("c_done_low", 32'(bus.o_done), 0);
    chk("c_busy", 32'(bus.o_busy), 1);
    chk("c_state_run", 32'(dbg_state), 1);
    n = 0;
    step();
    chk("c_flag1_pulse", 32'(bus.flag), 0);
    chk("c_count1", 32'(bus.count), 1);
    wait_flag("c_flag2", 200);
    chk("c_flag2_time", 32'(n), 80);
    chk("c_done2", 32'(bus.o_done), 1);

    // Abort at count=40 together with start and hold
    start_blk(7'd79);
    wait_count("d_reach40", 40, 100);
    bus.i_abort    = 1'b1;
    bus.i_start    = 1'b1;
    bus.i_hold     = 1'b1;
    bus.i_last_cnt = 7'd5;
    step();
    bus.i_abort    = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_hold     = 1'b0;
    bus.i_last_cnt = '0;
    chk("d_count", 32'(bus.count), 0);
    chk("d_state", 32'(dbg_state), 0);
    chk("d_flag", 32'(bus.flag), 0);
    chk("d_done", 32'(bus.o_done), 0);
    chk("d_busy", 32'(bus.o_busy), 0);
    step();
    chk("d_idle_stay", 32'(dbg_state), 0);

    // Oversized terminal count clamps to 79
    start_blk(7'd127);
    wait_flag("e_flag", 200);
    chk("e_flag_time", 32'(n), 81);
    chk("e_count", 32'(bus.count), 79);

    // last=0: one RUN cycle, flag two cycles after start
    start_blk(7'd0);
    chk("f_count", 32'(bus.count), 0);
    chk("f_busy", 32'(bus.o_busy), 1);
    chk("f_flag_early", 32'(bus.flag), 0);
    chk("f_sched", 32'(bus.o_sched_sel), 1);
    step();
    chk("f_flag", 32'(bus.flag), 1);
    chk("f_done", 32'(bus.o_done), 1);
    chk("f_n", 32'(n), 2);

    // Hold in the terminal cycle suppresses terminal detection
    start_blk(7'd5);
    wait_count("g_reach5", 5, 20);
    bus.i_hold = 1'b1;
    step();
    chk("g_hold_flag", 32'(bus.flag), 0);
    chk("g_hold_count", 32'(bus.count), 5);
    chk("g_hold_busy", 32'(bus.o_busy), 1);
    bus.i_hold = 1'b0;
    step();
    chk("g_flag", 32'(bus.flag), 1);
    chk("g_count", 32'(bus.count), 5);

    // Asynchronous reset mid-block at count=20
    start_blk(7'd79);
    wait_count("h_reach20", 20, 40);
    #2;
    reset_n = 1'b0;
    #1;
    chk("h_count", 32'(bus.count), 0);
    chk("h_flag", 32'(bus.flag), 0);
    chk("h_busy", 32'(bus.o_busy), 0);
    chk("h_done", 32'(bus.o_done), 0);
    chk("h_sched", 32'(bus.o_sched_sel), 0);
    chk("h_state", 32'(dbg_state), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("h_after_state", 32'(dbg_state), 0);

`ifdef SHA_SEQ_BLKCNT_EN
    // Block counter: three blocks, then clear coinciding with a flag
    repeat (3) begin
      start_blk(7'd0);
      step();
    end
    chk("i_blk3", 32'(o_blk_cnt), 3);
    start_blk(7'd0);
    i_blk_clr = 1'b1;
    step();
    i_blk_clr = 1'b0;
    chk("i_clr_flag", 32'(bus.flag), 1);
    chk("i_clr_wins", 32'(o_blk_cnt), 0);
    step();
    chk("i_clr_stay", 32'(o_blk_cnt), 0);
`endif

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
